// File: rtl/riscv_vpu_types_pkg.sv
// ============================================================================
// Module   : riscv_vpu_types_pkg
// Purpose  : Shared VPU request/response types and arbiter defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_vpu_types_pkg;

  localparam int VPU_ARB_NUM_REQ         = 4;
  localparam int VPU_ARB_MAX_OUTSTANDING = 4;
  // Wide enough for the largest supported requester count (8).
  localparam int VPU_ARB_ID_W            = 3;

  typedef logic [VPU_ARB_ID_W-1:0] vpu_arb_id_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] data;
  } vpu_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } vpu_rsp_t;

  // Requester index 'offset' positions after 'base', wrapping modulo n.
  function automatic vpu_arb_id_t vpu_arb_rr_slot(input vpu_arb_id_t base,
                                                  input int          offset,
                                                  input int          n);
    int sum;
    sum = int'(base) + offset;
    if (sum >= n) sum = sum - n;
    return vpu_arb_id_t'(sum);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vpu_arb_id_fifo.sv
// ============================================================================
// Module   : vpu_arb_id_fifo
// Purpose  : In-order FIFO of granted requester IDs awaiting a response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vpu_arb_id_fifo
  import riscv_vpu_types_pkg::*;
#(
  parameter int DEPTH = VPU_ARB_MAX_OUTSTANDING
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  vpu_arb_id_t push_id_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output vpu_arb_id_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  vpu_arb_id_t      r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

  // Never overrun or underrun, even if the caller misbehaves.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_id_i;
  end

endmodule

`default_nettype wire

// File: rtl/vpu_req_arbiter.sv
// ============================================================================
// Module   : vpu_req_arbiter
// Purpose  : Round-robin arbiter sharing one vpu_unit among NUM_REQ
//            requesters, with in-order response routing by ID FIFO.
// Config   : VPU_ARB_PERF_EN - enables grant/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vpu_req_arbiter
  import riscv_vpu_types_pkg::*;
#(
  parameter int NUM_REQ         = VPU_ARB_NUM_REQ,
  parameter int MAX_OUTSTANDING = VPU_ARB_MAX_OUTSTANDING
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  vpu_req_t [NUM_REQ-1:0]    req_i,
  output logic     [NUM_REQ-1:0]    req_ready_o,
  output vpu_req_t                  vpu_req_o,
  input  logic                      vpu_req_ready_i,
  input  vpu_rsp_t                  vpu_rsp_i,
  output logic                      vpu_rsp_ready_o,
  output vpu_rsp_t [NUM_REQ-1:0]    rsp_o,
  input  logic     [NUM_REQ-1:0]    rsp_ready_i,
  output logic                      spurious_rsp_o,
  output logic [NUM_REQ-1:0][31:0]  perf_grant_cnt_o,
  output logic [31:0]               perf_stall_cnt_o
);

  vpu_arb_id_t              r_rr_ptr;
  logic                     r_spurious;
  logic [NUM_REQ-1:0]       w_valid_vec;
  logic [2*NUM_REQ-1:0]     w_dbl_vec;
  logic [NUM_REQ-1:0]       w_rot_vec;
  logic                     w_found;
  vpu_arb_id_t              w_grant_id;
  logic                     w_grant_vld;
  logic                     w_issue;
  logic                     w_pop;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  vpu_arb_id_t              w_head_id;

  for (genvar j = 0; j < NUM_REQ; j++) begin : g_valid_vec
    assign w_valid_vec[j] = req_i[j].valid;
  end

  // Rotate the valid vector so bit 0 is the requester at rr_ptr.
  assign w_dbl_vec = {w_valid_vec, w_valid_vec} >> r_rr_ptr;
  assign w_rot_vec = w_dbl_vec[NUM_REQ-1:0];

  // Pick the first valid requester at or after rr_ptr.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot_vec[i]) begin
        w_found    = 1'b1;
        w_grant_id = vpu_arb_rr_slot(r_rr_ptr, i, NUM_REQ);
      end
    end
  end

  // A full ID FIFO suppresses the grant entirely so the vpu_unit never sees
  // a valid request that the arbiter could not track; no pop bypass.
  assign w_grant_vld = w_found && !w_fifo_full;
  assign w_issue     = w_grant_vld && vpu_req_ready_i;

  // Forward the granted request and raise ready only on the granted lane.
  always_comb begin
    vpu_req_o   = '0;
    req_ready_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant_vld && (w_grant_id == vpu_arb_id_t'(j))) begin
        vpu_req_o       = req_i[j];
        vpu_req_o.valid = 1'b1;
        req_ready_o[j]  = vpu_req_ready_i;
      end
    end
  end

  // Route the response to the oldest outstanding requester; drop when empty.
  always_comb begin
    rsp_o           = '0;
    vpu_rsp_ready_o = 1'b1;
    if (!w_fifo_empty) begin
      vpu_rsp_ready_o = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (w_head_id == vpu_arb_id_t'(j)) begin
          rsp_o[j]        = vpu_rsp_i;
          vpu_rsp_ready_o = rsp_ready_i[j];
        end
      end
    end
  end

  assign w_pop = vpu_rsp_i.valid && vpu_rsp_ready_o && !w_fifo_empty;

  vpu_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_issue),
    .push_id_i (w_grant_id),
    .pop_i     (w_pop),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty),
    .head_o    (w_head_id)
  );

  // Advance the round-robin pointer past the granted requester on issue only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      if (w_grant_id == vpu_arb_id_t'(NUM_REQ - 1)) r_rr_ptr <= '0;
      else                                          r_rr_ptr <= w_grant_id + 1'b1;
    end
  end

  // Sticky record of a response arriving with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_spurious <= 1'b0;
    end else if (vpu_rsp_i.valid && w_fifo_empty) begin
      r_spurious <= 1'b1;
    end
  end

  assign spurious_rsp_o = r_spurious;

`ifdef VPU_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] r_grant_cnt;
  logic [31:0]              r_stall_cnt;
  logic                     w_any_valid;

  assign w_any_valid = |w_valid_vec;

  for (genvar j = 0; j < NUM_REQ; j++) begin : g_grant_cnt
    // Saturating count of issues granted to requester j.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_grant_cnt[j] <= '0;
      end else if (w_issue && (w_grant_id == vpu_arb_id_t'(j)) &&
                   (r_grant_cnt[j] != '1)) begin
        r_grant_cnt[j] <= r_grant_cnt[j] + 32'd1;
      end
    end
  end

  // Saturating count of cycles with demand but no issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_any_valid && !w_issue && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_grant_cnt_o = r_grant_cnt;
  assign perf_stall_cnt_o = r_stall_cnt;
`else
  assign perf_grant_cnt_o = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vpu_req_arbiter.sv
// ============================================================================
// Module   : tb_vpu_req_arbiter
// Purpose  : Directed self-checking bench for vpu_req_arbiter (4 requesters,
//            4 outstanding). Honours VPU_ARB_PERF_EN for counter expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vpu_req_arbiter;
  import riscv_vpu_types_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  vpu_req_t [3:0]      req_i;
  logic     [3:0]      req_ready_o;
  vpu_req_t            vpu_req_o;
  logic                vpu_req_ready_i;
  vpu_rsp_t            vpu_rsp_i;
  logic                vpu_rsp_ready_o;
  vpu_rsp_t [3:0]      rsp_o;
  logic     [3:0]      rsp_ready_i;
  logic                spurious_rsp_o;
  logic [3:0][31:0]    perf_grant_cnt_o;
  logic [31:0]         perf_stall_cnt_o;

  int vectors = 0;
  int errors  = 0;

  vpu_req_arbiter #(
    .NUM_REQ         (4),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .req_ready_o      (req_ready_o),
    .vpu_req_o        (vpu_req_o),
    .vpu_req_ready_i  (vpu_req_ready_i),
    .vpu_rsp_i        (vpu_rsp_i),
    .vpu_rsp_ready_o  (vpu_rsp_ready_o),
    .rsp_o            (rsp_o),
    .rsp_ready_i      (rsp_ready_i),
    .spurious_rsp_o   (spurious_rsp_o),
    .perf_grant_cnt_o (perf_grant_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vpu_req_t mk_req(input int id);
    vpu_req_t r;
    r.valid = 1'b1;
    r.op    = 4'(id + 3);
    r.data  = 32'hA000_0000 | 32'(id);
    return r;
  endfunction

  function automatic vpu_rsp_t mk_rsp(input logic [31:0] d);
    vpu_rsp_t r;
    r.valid = 1'b1;
    r.data  = d;
    return r;
  endfunction

  task automatic clear_inputs();
    req_i           = '0;
    vpu_req_ready_i = 1'b0;
    vpu_rsp_i       = '0;
    rsp_ready_i     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    clear_inputs();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    #1;
    vectors++; if (vpu_req_o !== '0) begin errors++; $display("FAIL reset_vpu_req: got %h want 0", vpu_req_o); end
    vectors++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready_o); end
    vectors++; if (vpu_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL reset_rsp_ready: got %b want 1", vpu_rsp_ready_o); end
    vectors++; if (rsp_o !== '0) begin errors++; $display("FAIL reset_rsp_o: got %h want 0", rsp_o); end
    vectors++; if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b want 0", spurious_rsp_o); end
    vectors++; if (perf_grant_cnt_o !== '0) begin errors++; $display("FAIL reset_perf_grant: got %h want 0", perf_grant_cnt_o); end
    vectors++; if (perf_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_perf_stall: got %0d want 0", perf_stall_cnt_o); end
  endtask

  task automatic test_round_robin();
    int order[4] = '{1, 2, 3, 0};
    vpu_rsp_t [3:0] exp_rsp;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      for (int j = 0; j < 4; j++) req_i[j] = mk_req(j);
      vpu_req_ready_i = 1'b1;
      #1;
      vectors++; if (vpu_req_o !== mk_req(k)) begin errors++; $display("FAIL rr_issue%0d_req: got %h want %h", k, vpu_req_o, mk_req(k)); end
      vectors++; if (req_ready_o !== (4'b1 << k)) begin errors++; $display("FAIL rr_issue%0d_ready: got %b want %b", k, req_ready_o, 4'b1 << k); end
    end
    // FIFO now holds four IDs: no further grant.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      #1;
      vectors++; if (vpu_req_o !== '0) begin errors++; $display("FAIL rr_full_req: got %h want 0", vpu_req_o); end
      vectors++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL rr_full_ready: got %b want 0000", req_ready_o); end
    end
    // Pop while full: still no issue in the same cycle.
    @(negedge clk_i);
    vpu_rsp_i   = mk_rsp(32'h0000_0055);
    rsp_ready_i = 4'hF;
    #1;
    exp_rsp = '0; exp_rsp[0] = mk_rsp(32'h0000_0055);
    vectors++; if (rsp_o !== exp_rsp) begin errors++; $display("FAIL rr_pop_route: got %h want %h", rsp_o, exp_rsp); end
    vectors++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL rr_no_bypass: got %b want 0000", req_ready_o); end
    // Next cycle a slot is free and requester 0 is granted again.
    @(negedge clk_i);
    vpu_rsp_i = '0;
    #1;
    vectors++; if (vpu_req_o !== mk_req(0)) begin errors++; $display("FAIL rr_fifth_req: got %h want %h", vpu_req_o, mk_req(0)); end
    vectors++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL rr_fifth_ready: got %b want 0001", req_ready_o); end
    // Drain: responses return in issue order 1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      req_i           = '0;
      vpu_req_ready_i = 1'b0;
      vpu_rsp_i       = mk_rsp(32'h0000_0100 + 32'(k));
      #1;
      exp_rsp = '0; exp_rsp[order[k]] = mk_rsp(32'h0000_0100 + 32'(k));
      vectors++; if (rsp_o !== exp_rsp) begin errors++; $display("FAIL rr_drain%0d: got %h want %h", k, rsp_o, exp_rsp); end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_rr_skip();
    vpu_rsp_t [3:0] exp_rsp;
    int exp_id[2] = '{3, 1};
    do_reset();
    // Issue requester 1 alone to move rr_ptr to 2.
    @(negedge clk_i);
    req_i[1] = mk_req(1); vpu_req_ready_i = 1'b1;
    #1;
    vectors++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL skip_setup: got %b want 0010", req_ready_o); end
    @(negedge clk_i);
    req_i = '0; vpu_rsp_i = mk_rsp(32'h1); rsp_ready_i = 4'hF;
    @(negedge clk_i);
    vpu_rsp_i = '0;
    req_i[1] = mk_req(1); req_i[3] = mk_req(3);
    #1;
    vectors++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL skip_grant3_ready: got %b want 1000", req_ready_o); end
    vectors++; if (vpu_req_o !== mk_req(3)) begin errors++; $display("FAIL skip_grant3_req: got %h want %h", vpu_req_o, mk_req(3)); end
    @(negedge clk_i);
    #1;
    vectors++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL skip_grant1_ready: got %b want 0010", req_ready_o); end
    vectors++; if (vpu_req_o !== mk_req(1)) begin errors++; $display("FAIL skip_grant1_req: got %h want %h", vpu_req_o, mk_req(1)); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      req_i = '0; vpu_req_ready_i = 1'b0;
      vpu_rsp_i = mk_rsp(32'h0000_0200 + 32'(k));
      #1;
      exp_rsp = '0; exp_rsp[exp_id[k]] = mk_rsp(32'h0000_0200 + 32'(k));
      vectors++; if (rsp_o !== exp_rsp) begin errors++; $display("FAIL skip_drain%0d: got %h want %h", k, rsp_o, exp_rsp); end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_in_order_rsp();
    int ids[3] = '{0, 2, 1};
    logic [31:0] dat[3] = '{32'hCAFE_0011, 32'hBEEF_0022, 32'hF00D_0033};
    vpu_rsp_t [3:0] exp_rsp;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      req_i = '0; req_i[ids[k]] = mk_req(ids[k]); vpu_req_ready_i = 1'b1;
      #1;
      vectors++; if (req_ready_o !== (4'b1 << ids[k])) begin errors++; $display("FAIL order_issue%0d: got %b want %b", k, req_ready_o, 4'b1 << ids[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      req_i = '0; vpu_req_ready_i = 1'b0;
      vpu_rsp_i = mk_rsp(dat[k]); rsp_ready_i = 4'hF;
      #1;
      exp_rsp = '0; exp_rsp[ids[k]] = mk_rsp(dat[k]);
      vectors++; if (rsp_o !== exp_rsp) begin errors++; $display("FAIL order_rsp%0d: got %h want %h", k, rsp_o, exp_rsp); end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_rsp_backpressure();
    vpu_rsp_t [3:0] exp_rsp;
    do_reset();
    @(negedge clk_i);
    req_i[3] = mk_req(3); vpu_req_ready_i = 1'b1;
    @(negedge clk_i);
    req_i = '0; req_i[1] = mk_req(1);
    #1;
    vectors++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_issue1: got %b want 0010", req_ready_o); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      req_i = '0; vpu_req_ready_i = 1'b0;
      vpu_rsp_i = mk_rsp(32'h0000_0077); rsp_ready_i = 4'b0111;
      #1;
      exp_rsp = '0; exp_rsp[3] = mk_rsp(32'h0000_0077);
      vectors++; if (vpu_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_ready: got %b want 0", k, vpu_rsp_ready_o); end
      vectors++; if (rsp_o !== exp_rsp) begin errors++; $display("FAIL bp_hold%0d_head: got %h want %h", k, rsp_o, exp_rsp); end
    end
    @(negedge clk_i);
    rsp_ready_i = 4'b1000;
    #1;
    vectors++; if (vpu_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", vpu_rsp_ready_o); end
    @(negedge clk_i);
    vpu_rsp_i = mk_rsp(32'h0000_0088); rsp_ready_i = 4'b0010;
    #1;
    exp_rsp = '0; exp_rsp[1] = mk_rsp(32'h0000_0088);
    vectors++; if (rsp_o !== exp_rsp) begin errors++; $display("FAIL bp_next_head: got %h want %h", rsp_o, exp_rsp); end
    @(negedge clk_i);
    clear_inputs();
    #1;
    vectors++; if (vpu_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL bp_empty_ready: got %b want 1", vpu_rsp_ready_o); end
    vectors++; if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL bp_no_spurious: got %b want 0", spurious_rsp_o); end
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk_i);
    vpu_rsp_i = mk_rsp(32'hDEAD_0001);
    #1;
    vectors++; if (vpu_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL spur_drop_ready: got %b want 1", vpu_rsp_ready_o); end
    vectors++; if (rsp_o !== '0) begin errors++; $display("FAIL spur_no_route: got %h want 0", rsp_o); end
    vectors++; if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL spur_not_yet: got %b want 0", spurious_rsp_o); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      vpu_rsp_i = '0;
      #1;
      vectors++; if (spurious_rsp_o !== 1'b1) begin errors++; $display("FAIL spur_sticky%0d: got %b want 1", k, spurious_rsp_o); end
    end
    // Reset with an ID outstanding discards it.
    @(negedge clk_i);
    req_i[0] = mk_req(0); vpu_req_ready_i = 1'b1;
    do_reset();
    @(negedge clk_i);
    #1;
    vectors++; if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL spur_cleared: got %b want 0", spurious_rsp_o); end
    vpu_rsp_i = mk_rsp(32'hDEAD_0002);
    #1;
    vectors++; if (rsp_o !== '0) begin errors++; $display("FAIL spur_after_reset_route: got %h want 0", rsp_o); end
    @(negedge clk_i);
    vpu_rsp_i = '0;
    #1;
    vectors++; if (spurious_rsp_o !== 1'b1) begin errors++; $display("FAIL spur_after_reset: got %b want 1", spurious_rsp_o); end
    do_reset();
  endtask

  task automatic test_perf();
    vpu_rsp_t [3:0] exp_rsp;
    logic [31:0] exp_grant;
    logic [31:0] exp_stall;
    do_reset();
    // Ten issues to requester 2; responses pop in parallel after the first.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      req_i[2] = mk_req(2); vpu_req_ready_i = 1'b1;
      rsp_ready_i = 4'hF;
      vpu_rsp_i = (k == 0) ? vpu_rsp_t'('0) : mk_rsp(32'h0000_0300 + 32'(k));
      #1;
      vectors++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL perf_issue%0d: got %b want 0100", k, req_ready_o); end
      if (k != 0) begin
        exp_rsp = '0; exp_rsp[2] = mk_rsp(32'h0000_0300 + 32'(k));
        vectors++; if (rsp_o !== exp_rsp) begin errors++; $display("FAIL perf_pushpop%0d: got %h want %h", k, rsp_o, exp_rsp); end
      end
    end
    // Five stall cycles: request held, vpu_unit not ready.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      vpu_req_ready_i = 1'b0; vpu_rsp_i = '0;
      #1;
      vectors++; if (vpu_req_o !== mk_req(2)) begin errors++; $display("FAIL perf_hold%0d: got %h want %h", k, vpu_req_o, mk_req(2)); end
    end
    // Drain the single remaining ID.
    @(negedge clk_i);
    req_i = '0; vpu_rsp_i = mk_rsp(32'h0000_03FF);
    #1;
    exp_rsp = '0; exp_rsp[2] = mk_rsp(32'h0000_03FF);
    vectors++; if (rsp_o !== exp_rsp) begin errors++; $display("FAIL perf_drain: got %h want %h", rsp_o, exp_rsp); end
    @(negedge clk_i);
    vpu_rsp_i = '0;
    #1;
`ifdef VPU_ARB_PERF_EN
    exp_grant = 32'd10;
    exp_stall = 32'd5;
`else
    exp_grant = 32'd0;
    exp_stall = 32'd0;
`endif
    vectors++; if (perf_grant_cnt_o[2] !== exp_grant) begin errors++; $display("FAIL perf_grant2: got %0d want %0d", perf_grant_cnt_o[2], exp_grant); end
    vectors++; if (perf_grant_cnt_o[0] !== 32'd0) begin errors++; $display("FAIL perf_grant0: got %0d want 0", perf_grant_cnt_o[0]); end
    vectors++; if (perf_stall_cnt_o !== exp_stall) begin errors++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt_o, exp_stall); end
    vectors++; if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL perf_balanced: got %b want 0", spurious_rsp_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_rr_skip();
    test_in_order_rsp();
    test_rsp_backpressure();
    test_spurious();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/vpu_req_arbiter.md
VPU_REQ_ARBITER -- requirements
Module: vpu_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one vpu_unit (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, meaning in-flight requests tracked (power of two, >=2).
REQ-003 clk_i  input  1  clock; single clock domain, all logic on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 req_i  input  vpu_req_t[NUM_REQ]  per-requester request; .valid is request-valid.
REQ-006 req_ready_o  output  [NUM_REQ]  per-requester accept.
REQ-007 vpu_req_o  output  vpu_req_t  request to vpu_unit.
REQ-008 vpu_req_ready_i  input  1  vpu_unit accepts request.
REQ-009 vpu_rsp_i  input  vpu_rsp_t  response from vpu_unit; .valid is response-valid.
REQ-010 vpu_rsp_ready_o  output  1  response accepted.
REQ-011 rsp_o  output  vpu_rsp_t[NUM_REQ]  per-requester response.
REQ-012 rsp_ready_i  input  [NUM_REQ]  per-requester response accept.
REQ-013 spurious_rsp_o  output  1  sticky flag: response arrived with nothing outstanding.
REQ-014 perf_grant_cnt_o  output  32x[NUM_REQ]  grants per requester (see Configuration).
REQ-015 perf_stall_cnt_o  output  32  cycles with any request pending but none issued.

Function
REQ-016 Round-robin arbitration: combinational grant to first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-017 vpu_req_o SHALL equal granted req_i with .valid=1; with no grant, vpu_req_o='0.
REQ-018 Issue (handshake) = vpu_req_o.valid && vpu_req_ready_i; req_ready_o[g]=vpu_req_ready_i && issue-allowed for granted g only; others 0.
REQ-019 Issue-allowed SHALL be 0 when outstanding count == MAX_OUTSTANDING, even if a response pops that same cycle (no bypass).
REQ-020 On issue: rr_ptr <= (g+1) mod NUM_REQ; granted ID pushed to in-order ID FIFO; count increments.
REQ-021 rr_ptr SHALL not move without an issue; vpu_req_o held stable while vpu_req_ready_i=0 only if requester holds valid (no re-arbitration lock required).
REQ-022 Response routing: head ID h of FIFO selects rsp_o[h]=vpu_rsp_i; all other rsp_o='0; vpu_rsp_ready_o=rsp_ready_i[h] when FIFO non-empty.
REQ-023 Pop on vpu_rsp_i.valid && vpu_rsp_ready_o; simultaneous push and pop leave count unchanged, pointers both advance.
REQ-024 vpu_rsp_i.valid with empty FIFO: vpu_rsp_ready_o=1 (drop), spurious_rsp_o set to 1 until reset; no rsp_o driven.
REQ-025 Latency: request to vpu_req_o zero cycles (combinational); response to rsp_o zero cycles.
REQ-026 FIFO read/write pointers wrap modulo MAX_OUTSTANDING; count width clog2(MAX_OUTSTANDING)+1.

Reset
REQ-027 On rst_i=1 at clock edge: rr_ptr=0, FIFO empty, count=0, spurious_rsp_o=0, perf counters=0.
REQ-028 Reset mid-operation SHALL discard all outstanding IDs; responses arriving afterwards are spurious per REQ-024.

Configuration
REQ-029 Macro VPU_ARB_PERF_EN: defined -> perf_grant_cnt_o increments on each issue for granted ID, perf_stall_cnt_o increments each cycle any req_i.valid=1 and no issue; both saturate at 2^32-1.
REQ-030 Macro VPU_ARB_PERF_EN undefined -> counter registers absent, perf outputs tied to '0; ports remain.

Structure
REQ-031 VPU_ARB_NUM_REQ and VPU_ARB_MAX_OUTSTANDING defaults and vpu_arb_id_t SHALL live in riscv_vpu_types_pkg alongside vpu_req_t/vpu_rsp_t.
REQ-032 ID FIFO SHALL be sub-module vpu_arb_id_fifo (push/pop/full/empty/head, synchronous active-high reset).

Verification
REQ-033 All four requesters valid from reset, vpu_req_ready_i=1 -> issue order 0,1,2,3,0; stalls once count=4 with no responses.
REQ-034 Requesters 1 and 3 valid, rr_ptr=2 -> grant 3, then 1; requester 0/2 ready stays 0.
REQ-035 Issue 0,2,1, return three responses -> rsp_o[0], rsp_o[2], rsp_o[1] in order, values unchanged.
REQ-036 rsp_ready_i[head]=0 for 3 cycles -> vpu_rsp_ready_o=0, FIFO head unchanged; pop on 4th cycle.
REQ-037 vpu_rsp_i.valid with empty FIFO -> spurious_rsp_o=1 next cycle, stays 1; cleared by rst_i.
REQ-038 With VPU_ARB_PERF_EN, 10 grants to requester 2 and 5 stall cycles -> perf_grant_cnt_o[2]=10, perf_stall_cnt_o=5; without macro both read 0.
